// File: rtl/spi_clk_pkg.sv
// Shared types and helpers for the SPI clock engine: one-hot phase encoding,
// clock-mode constants and the minimum-value normalisation for timing inputs.
package spi_clk_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_SETUP = 5'b00010,
    ST_DATA  = 5'b00100,
    ST_HOLD  = 5'b01000,
    ST_GAP   = 5'b10000
  } spiState_t;

  localparam logic CPOL_IDLE_LOW    = 1'b0;
  localparam logic CPHA_LEAD_SAMPLE = 1'b0;
  localparam logic CPHA_LEAD_SHIFT  = 1'b1;

  localparam logic [7:0] MIN_PERIOD = 8'd2;
  localparam logic [7:0] MIN_DELAY  = 8'd1;

  // Raises a timing value to its smallest usable setting.
  function automatic logic [7:0] normMin(input logic [7:0] value, input logic [7:0] minValue);
    return (value < minValue) ? minValue : value;
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK divider: runs a per-bit period counter while the engine is in DATA and
// reports leading/trailing ticks for the edge being registered this cycle.
module spi_sclk_div (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_run,
  input  logic [7:0] i_period,
  input  logic       i_cpol,
  output logic       o_sclk,
  output logic       o_lead,
  output logic       o_trail,
  output logic       o_wrap
);

  logic [7:0] r_cnt;
  logic       r_sclk;
  logic [7:0] w_h1;
  logic [7:0] w_cntNext;

  // The active half gets the extra cycle when the period is odd.
  assign w_h1      = i_period - {1'b0, i_period[7:1]};
  assign o_wrap    = (r_cnt == (i_period - 8'd1));
  assign w_cntNext = o_wrap ? 8'd0 : (r_cnt + 8'd1);
  assign o_lead    = i_start | (i_run & o_wrap);
  assign o_trail   = i_run & (w_cntNext == w_h1);
  assign o_sclk    = r_sclk;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= 8'd0;
      r_sclk <= 1'b0;
    end else if (i_start) begin
      r_cnt  <= 8'd0;
      r_sclk <= ~i_cpol;
    end else if (i_run) begin
      r_cnt <= w_cntNext;
      if (o_lead) begin
        r_sclk <= ~i_cpol;
      end else if (o_trail) begin
        r_sclk <= i_cpol;
      end
    end else begin
      r_cnt  <= 8'd0;
      r_sclk <= i_cpol;
    end
  end

endmodule

// File: rtl/spi_clk_engine.sv
// SPI master timing engine: sequences slave selects, SCLK and shift/sample
// strobes through setup, data, hold and inter-frame gap, with burst frames.
module spi_clk_engine
  import spi_clk_pkg::*;
#(
  parameter int MAX_FRAME_BITS = 32,
  parameter int NUM_SS         = 4,
  parameter int FB_W           = $clog2(MAX_FRAME_BITS + 1),
  localparam int SS_W          = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_spi_start,
  input  logic [FB_W-1:0]   i_frame_bits,
  input  logic [SS_W-1:0]   i_ss_sel,
  input  logic [7:0]        i_clk_period,
  input  logic [7:0]        i_setup_cycles,
  input  logic [7:0]        i_hold_cycles,
  input  logic [7:0]        i_tx2tx_cycles,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_burst,
  output logic              o_busy,
  output logic [NUM_SS-1:0] o_ss_n,
  output logic              o_sclk,
  output logic              o_frame_start,
  output logic              o_shift_strobe,
  output logic              o_sample_strobe,
  output logic              o_frame_done
);

  // Out-of-range indices match no bit, so the frame runs with no slave selected.
  function automatic logic [NUM_SS-1:0] selMask(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] mask;
    mask = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (sel == SS_W'(i)) mask[i] = 1'b0;
    end
    return mask;
  endfunction

  spiState_t         r_state;
  logic [7:0]        r_cnt;
  logic [FB_W-1:0]   r_bitCnt;
  logic              r_busy;
  logic [NUM_SS-1:0] r_ssN;
  logic              r_frameStart;
  logic              r_done;
  logic              r_shift;
  logic              r_sample;

  logic [FB_W-1:0]   r_frameBits;
  logic [7:0]        r_period;
  logic [7:0]        r_setup;
  logic [7:0]        r_hold;
  logic [7:0]        r_gap;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_burst;

  logic              w_idleStart;
  logic              w_holdExit;
  logic              w_burstRelatch;
  logic              w_latch;
  logic              w_cpolNext;
  logic [FB_W-1:0]   w_frameBitsN;
  logic              w_lastBit;
  logic              w_divStart;
  logic              w_divRun;
  logic              w_sclk;
  logic              w_lead;
  logic              w_trail;
  logic              w_wrap;

  assign w_idleStart    = (r_state == ST_IDLE) && i_spi_start;
  assign w_holdExit     = (r_state == ST_HOLD) && (r_cnt == r_hold);
  assign w_burstRelatch = w_holdExit && r_burst && i_spi_start;
  assign w_latch        = w_idleStart || w_burstRelatch;
  // The divider must see the new polarity on the very edge that latches it.
  assign w_cpolNext     = w_latch ? i_cpol : r_cpol;
  assign w_frameBitsN   = ((i_frame_bits == '0) || (i_frame_bits > FB_W'(MAX_FRAME_BITS)))
                        ? FB_W'(MAX_FRAME_BITS) : i_frame_bits;
  assign w_lastBit      = (r_bitCnt == (r_frameBits - FB_W'(1)));
  assign w_divStart     = (r_state == ST_SETUP) && (r_cnt == r_setup);
  assign w_divRun       = (r_state == ST_DATA) && !(w_wrap && w_lastBit);

  spi_sclk_div u_sclkDiv (
    .i_clk    (i_sys_clk),
    .i_rst    (i_sys_rst),
    .i_start  (w_divStart),
    .i_run    (w_divRun),
    .i_period (r_period),
    .i_cpol   (w_cpolNext),
    .o_sclk   (w_sclk),
    .o_lead   (w_lead),
    .o_trail  (w_trail),
    .o_wrap   (w_wrap)
  );

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_frameBits <= FB_W'(MAX_FRAME_BITS);
      r_period    <= MIN_PERIOD;
      r_setup     <= MIN_DELAY;
      r_hold      <= MIN_DELAY;
      r_gap       <= 8'd0;
      r_cpol      <= CPOL_IDLE_LOW;
      r_cpha      <= CPHA_LEAD_SAMPLE;
      r_burst     <= 1'b0;
    end else if (w_latch) begin
      r_frameBits <= w_frameBitsN;
      r_period    <= normMin(i_clk_period, MIN_PERIOD);
      r_setup     <= normMin(i_setup_cycles, MIN_DELAY);
      r_hold      <= normMin(i_hold_cycles, MIN_DELAY);
      r_gap       <= i_tx2tx_cycles;
      r_cpol      <= i_cpol;
      r_cpha      <= i_cpha;
      r_burst     <= i_burst;
    end
  end

  // Phase counter r_cnt counts 1..limit inside SETUP, HOLD and GAP.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_bitCnt     <= '0;
      r_busy       <= 1'b0;
      r_ssN        <= '1;
      r_frameStart <= 1'b0;
      r_done       <= 1'b0;
      r_shift      <= 1'b0;
      r_sample     <= 1'b0;
    end else begin
      r_frameStart <= 1'b0;
      r_done       <= 1'b0;
      r_shift      <= 1'b0;
      r_sample     <= 1'b0;

      // In mode 0 the final trailing edge has no next bit to shift out.
      if (w_lead) begin
        if (r_cpha == CPHA_LEAD_SHIFT) r_shift <= 1'b1;
        else                           r_sample <= 1'b1;
      end
      if (w_trail) begin
        if (r_cpha == CPHA_LEAD_SHIFT) r_sample <= 1'b1;
        else if (!w_lastBit)           r_shift <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_spi_start) begin
            r_state      <= ST_SETUP;
            r_cnt        <= 8'd1;
            r_busy       <= 1'b1;
            r_ssN        <= selMask(i_ss_sel);
            r_frameStart <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (r_cnt == r_setup) begin
            r_state  <= ST_DATA;
            r_bitCnt <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DATA: begin
          if (w_wrap) begin
            if (w_lastBit) begin
              r_state <= ST_HOLD;
              r_cnt   <= 8'd1;
            end else begin
              r_bitCnt <= r_bitCnt + FB_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (w_holdExit) begin
            r_done <= 1'b1;
            r_cnt  <= 8'd1;
            if (w_burstRelatch) begin
              r_state      <= ST_SETUP;
              r_frameStart <= 1'b1;
            end else begin
              r_ssN <= '1;
              if (r_gap == 8'd0) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= ST_GAP;
              end
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == r_gap) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ssN   <= '1;
        end
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_ss_n          = r_ssN;
  assign o_sclk          = w_sclk;
  assign o_frame_start   = r_frameStart;
  assign o_shift_strobe  = r_shift;
  assign o_sample_strobe = r_sample;
  assign o_frame_done    = r_done;

endmodule

// File: tb/tb_spi_clk_engine.sv
// Directed bench for spi_clk_engine: runs frames, records per-cycle output
// behaviour and compares it with hand-computed timing for each scenario.
module tb_spi_clk_engine;

  localparam int MAX_FRAME_BITS = 32;
  localparam int NUM_SS         = 4;
  localparam int FB_W           = 6;

  logic              i_sys_clk = 1'b0;
  logic              i_sys_rst;
  logic              i_spi_start;
  logic [FB_W-1:0]   i_frame_bits;
  logic [1:0]        i_ss_sel;
  logic [7:0]        i_clk_period;
  logic [7:0]        i_setup_cycles;
  logic [7:0]        i_hold_cycles;
  logic [7:0]        i_tx2tx_cycles;
  logic              i_cpol;
  logic              i_cpha;
  logic              i_burst;
  logic              o_busy;
  logic [NUM_SS-1:0] o_ss_n;
  logic              o_sclk;
  logic              o_frame_start;
  logic              o_shift_strobe;
  logic              o_sample_strobe;
  logic              o_frame_done;

  int checks = 0;
  int errors = 0;

  // Results of the latest captured frame; X is the edge at which a value is seen,
  // counted from the edge that sampled the start request.
  int resTimedOut, resFrameStartAt, resFrameStarts, resSsLowAt, resSsHighAt;
  int resFirstLead, resLeads, resTrails, resLeadCycles;
  int resSampleTotal, resShiftTotal, resSampleOnLead, resSampleOnTrail;
  int resShiftOnLead, resShiftOnTrail;
  int resDones, resDoneAt, resDoneLast, resBusyLowAt, resIdleSclk;

  spi_clk_engine #(
    .MAX_FRAME_BITS (MAX_FRAME_BITS),
    .NUM_SS         (NUM_SS),
    .FB_W           (FB_W)
  ) dut (
    .i_sys_clk       (i_sys_clk),
    .i_sys_rst       (i_sys_rst),
    .i_spi_start     (i_spi_start),
    .i_frame_bits    (i_frame_bits),
    .i_ss_sel        (i_ss_sel),
    .i_clk_period    (i_clk_period),
    .i_setup_cycles  (i_setup_cycles),
    .i_hold_cycles   (i_hold_cycles),
    .i_tx2tx_cycles  (i_tx2tx_cycles),
    .i_cpol          (i_cpol),
    .i_cpha          (i_cpha),
    .i_burst         (i_burst),
    .o_busy          (o_busy),
    .o_ss_n          (o_ss_n),
    .o_sclk          (o_sclk),
    .o_frame_start   (o_frame_start),
    .o_shift_strobe  (o_shift_strobe),
    .o_sample_strobe (o_sample_strobe),
    .o_frame_done    (o_frame_done)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int bits, input int sel, input int period, input int setup,
                               input int hold, input int gap, input int cpol, input int cpha,
                               input int burst);
    i_frame_bits   = FB_W'(bits);
    i_ss_sel       = 2'(sel);
    i_clk_period   = 8'(period);
    i_setup_cycles = 8'(setup);
    i_hold_cycles  = 8'(hold);
    i_tx2tx_cycles = 8'(gap);
    i_cpol         = 1'(cpol);
    i_cpha         = 1'(cpha);
    i_burst        = 1'(burst);
  endtask

  // Raises start, then samples every cycle at the falling edge until o_busy drops.
  task automatic captureFrame(input int holdStartDones, input int selMask, input int cpol);
    int  sclkNow;
    int  prev;
    bit  isLead;
    bit  isTrail;
    i_spi_start = 1'b1;
    @(posedge i_sys_clk);
    resTimedOut = 1;      resFrameStartAt = -1; resFrameStarts = 0;
    resSsLowAt = -1;      resSsHighAt = -1;     resFirstLead = -1;
    resLeads = 0;         resTrails = 0;        resLeadCycles = 0;
    resSampleTotal = 0;   resShiftTotal = 0;    resSampleOnLead = 0;
    resSampleOnTrail = 0; resShiftOnLead = 0;   resShiftOnTrail = 0;
    resDones = 0;         resDoneAt = -1;       resDoneLast = -1;
    resBusyLowAt = -1;    resIdleSclk = -1;
    prev = cpol;
    for (int x = 1; x <= 600; x++) begin
      @(negedge i_sys_clk);
      sclkNow = int'(o_sclk);
      isLead  = (sclkNow != cpol) && (prev == cpol);
      isTrail = (sclkNow == cpol) && (prev != cpol);
      if (isLead) begin
        resLeads++;
        if (resFirstLead < 0) resFirstLead = x;
      end
      if (isTrail) resTrails++;
      if (o_busy && (sclkNow != cpol)) resLeadCycles++;
      if (o_sample_strobe) begin
        resSampleTotal++;
        if (isLead)  resSampleOnLead++;
        if (isTrail) resSampleOnTrail++;
      end
      if (o_shift_strobe) begin
        resShiftTotal++;
        if (isLead)  resShiftOnLead++;
        if (isTrail) resShiftOnTrail++;
      end
      if (o_frame_start) begin
        resFrameStarts++;
        if (resFrameStartAt < 0) resFrameStartAt = x;
      end
      if ((int'(o_ss_n) == selMask) && (resSsLowAt < 0)) resSsLowAt = x;
      if ((resSsLowAt >= 0) && (resSsHighAt < 0) && (o_ss_n == '1)) resSsHighAt = x;
      if (o_frame_done) begin
        resDones++;
        if (resDoneAt < 0) resDoneAt = x;
        resDoneLast = x;
      end
      if (resDones >= holdStartDones) i_spi_start = 1'b0;
      if (!o_busy) begin
        resBusyLowAt = x;
        resIdleSclk  = sclkNow;
        resTimedOut  = 0;
        break;
      end
      prev = sclkNow;
    end
    i_spi_start = 1'b0;
  endtask

  task automatic verifyFrame(input string tag, input int cpha, input int expStarts,
                             input int expFirstLead, input int expLeads, input int expLeadCycles,
                             input int expSample, input int expShift, input int expDones,
                             input int expDoneAt, input int expDoneLast, input int expBusyLowAt,
                             input int expIdleSclk);
    checkOutput({tag, ".timeout"},      resTimedOut,     0);
    checkOutput({tag, ".frameStartAt"}, resFrameStartAt, 1);
    checkOutput({tag, ".frameStarts"},  resFrameStarts,  expStarts);
    checkOutput({tag, ".ssLowAt"},      resSsLowAt,      1);
    checkOutput({tag, ".firstLead"},    resFirstLead,    expFirstLead);
    checkOutput({tag, ".leads"},        resLeads,        expLeads);
    checkOutput({tag, ".trails"},       resTrails,       expLeads);
    checkOutput({tag, ".leadCycles"},   resLeadCycles,   expLeadCycles);
    checkOutput({tag, ".sampleTotal"},  resSampleTotal,  expSample);
    checkOutput({tag, ".shiftTotal"},   resShiftTotal,   expShift);
    if (cpha == 0) begin
      checkOutput({tag, ".sampleOnLead"},  resSampleOnLead,  expSample);
      checkOutput({tag, ".shiftOnTrail"},  resShiftOnTrail,  expShift);
    end else begin
      checkOutput({tag, ".shiftOnLead"},   resShiftOnLead,   expShift);
      checkOutput({tag, ".sampleOnTrail"}, resSampleOnTrail, expSample);
    end
    checkOutput({tag, ".dones"},        resDones,        expDones);
    checkOutput({tag, ".doneAt"},       resDoneAt,       expDoneAt);
    checkOutput({tag, ".doneLast"},     resDoneLast,     expDoneLast);
    checkOutput({tag, ".ssHighAt"},     resSsHighAt,     expDoneLast);
    checkOutput({tag, ".busyLowAt"},    resBusyLowAt,    expBusyLowAt);
    checkOutput({tag, ".idleSclk"},     resIdleSclk,     expIdleSclk);
  endtask

  initial begin
    int doneSeen;
    int busySeen;
    i_sys_rst   = 1'b1;
    i_spi_start = 1'b0;
    applyStimulus(8, 1, 4, 2, 3, 4, 0, 0, 0);
    repeat (3) @(posedge i_sys_clk);
    #1 i_sys_rst = 1'b0;
    @(negedge i_sys_clk);
    checkOutput("reset.busy",   int'(o_busy),          0);
    checkOutput("reset.ssN",    int'(o_ss_n),          15);
    checkOutput("reset.sclk",   int'(o_sclk),          0);
    checkOutput("reset.start",  int'(o_frame_start),   0);
    checkOutput("reset.shift",  int'(o_shift_strobe),  0);
    checkOutput("reset.sample", int'(o_sample_strobe), 0);
    checkOutput("reset.done",   int'(o_frame_done),    0);

    // Mode 0, P=4, N=8, S=2, H=3, T=4, slave 1.
    captureFrame(0, 13, 0);
    verifyFrame("mode0", 0, 1, 3, 8, 16, 8, 7, 1, 38, 38, 42, 0);

    // Mode 3, P=5: active (low) half is 3 cycles per bit, idles high afterwards.
    applyStimulus(8, 1, 5, 2, 3, 4, 1, 1, 0);
    captureFrame(0, 13, 1);
    verifyFrame("mode3", 1, 1, 3, 8, 24, 8, 8, 1, 46, 46, 50, 1);

    // Zero frame length and all-zero timing: 32 bits at P=2, S=H=1, no gap.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    captureFrame(0, 13, 0);
    verifyFrame("bits0", 0, 1, 2, 32, 32, 32, 31, 1, 67, 67, 67, 0);

    // Oversized frame length, started on the first idle edge after the previous done.
    applyStimulus(40, 1, 0, 0, 0, 0, 0, 0, 0);
    captureFrame(0, 13, 0);
    verifyFrame("bits40", 0, 1, 2, 32, 32, 32, 31, 1, 67, 67, 67, 0);

    // Three burst frames of 16 bits with start held through the second done.
    applyStimulus(16, 1, 4, 2, 3, 2, 0, 0, 1);
    captureFrame(2, 13, 0);
    verifyFrame("burst", 0, 3, 3, 48, 96, 48, 45, 3, 70, 208, 210, 0);

    // Reset in the middle of a CPOL=1 frame.
    applyStimulus(8, 1, 4, 2, 3, 4, 1, 0, 0);
    i_spi_start = 1'b1;
    @(posedge i_sys_clk);
    #1 i_spi_start = 1'b0;
    repeat (10) @(posedge i_sys_clk);
    #1;
    checkOutput("midReset.busyBefore", int'(o_busy), 1);
    checkOutput("midReset.ssBefore",   int'(o_ss_n), 13);
    i_sys_rst = 1'b1;
    @(posedge i_sys_clk);
    #1 i_sys_rst = 1'b0;
    @(negedge i_sys_clk);
    checkOutput("midReset.ssN",  int'(o_ss_n),       15);
    checkOutput("midReset.sclk", int'(o_sclk),       0);
    checkOutput("midReset.busy", int'(o_busy),       0);
    checkOutput("midReset.done", int'(o_frame_done), 0);
    doneSeen = 0;
    busySeen = 0;
    repeat (40) begin
      @(negedge i_sys_clk);
      if (o_frame_done) doneSeen++;
      if (o_busy)       busySeen++;
    end
    checkOutput("midReset.lateDone", doneSeen, 0);
    checkOutput("midReset.lateBusy", busySeen, 0);

    // A fresh frame after the reset behaves like the first one.
    applyStimulus(8, 1, 4, 2, 3, 4, 0, 0, 0);
    captureFrame(0, 13, 0);
    verifyFrame("afterReset", 0, 1, 3, 8, 16, 8, 7, 1, 38, 38, 42, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
